// File: rtl/leg_pkg.sv
// Shared types for the dispatch slice: RS identifiers, register status entries,
// the holding-register payload and the operand lookup helper.
package leg_pkg;

   localparam int TAG_W_DFLT = 4;
   localparam int NUM_REGS   = 32;

   typedef enum logic [3:0] {
      RS_NONE   = 4'd0,
      RS_ALU    = 4'd1,
      RS_MULDIV = 4'd2,
      RS_BRANCH = 4'd3,
      RS_LSU    = 4'd4
   } rs_id_t;

   typedef struct packed {
      logic                  busy;
      logic [TAG_W_DFLT-1:0] tag;
   } reg_status_t;

   typedef struct packed {
      rs_id_t                station;
      logic [5:0]            alu_fn;
      logic [15:0]           immediate;
      logic [4:0]            src1_reg;
      logic [4:0]            src2_reg;
      reg_status_t           src1;
      reg_status_t           src2;
      logic                  has_target;
      logic [TAG_W_DFLT-1:0] dst_tag;
   } dispatch_payload_t;

   // Operand view after a CDB broadcast in the same cycle: a matching tag is no longer busy.
   function automatic reg_status_t lookup(input logic has, input reg_status_t e,
                                          input logic cdb_v, input logic [TAG_W_DFLT-1:0] cdb_t);
      reg_status_t r;
      r = '0;
      if (has) begin
         r.tag  = e.tag;
         r.busy = e.busy && !(cdb_v && (e.tag == cdb_t));
      end
      return r;
   endfunction

endpackage

// File: rtl/reg_status_table.sv
// 32-entry register status table: busy bit plus producer tag per architectural register.
// Two combinational read ports, one allocate port, CDB clear and flush.
module reg_status_table
   import leg_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic [4:0]            rd_addr1,
   input  logic [4:0]            rd_addr2,
   output reg_status_t           rd_data1,
   output reg_status_t           rd_data2,
   input  logic                  alloc_en,
   input  logic [4:0]            alloc_addr,
   input  logic [TAG_W_DFLT-1:0] alloc_tag,
   input  logic                  cdb_valid,
   input  logic [TAG_W_DFLT-1:0] cdb_tag
);

   reg_status_t table_q [NUM_REGS];

   assign rd_data1 = (rd_addr1 == 5'd0) ? '0 : table_q[rd_addr1];
   assign rd_data2 = (rd_addr2 == 5'd0) ? '0 : table_q[rd_addr2];

   // Allocation of an entry takes priority over a CDB clear of that same entry.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_REGS; i++) begin
         if (rst) begin
            table_q[i] <= '0;
         end else if (flush) begin
            table_q[i].busy <= 1'b0;
         end else if (alloc_en && (alloc_addr == 5'(i)) && (i != 0)) begin
            table_q[i].busy <= 1'b1;
            table_q[i].tag  <= alloc_tag;
         end else if (cdb_valid && table_q[i].busy && (table_q[i].tag == cdb_tag)) begin
            table_q[i].busy <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/dispatch_unit.sv
// Dispatch stage: renames sources, allocates destination tags, holds one instruction
// and steers it to its reservation station. Optional counters under DISPATCH_STATS_EN.
module dispatch_unit
   import leg_pkg::*;
#(
   parameter int TAG_W  = TAG_W_DFLT,
   parameter int NUM_RS = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [5:0]        in_operation,
   input  logic [5:0]        in_alu_fn,
   input  logic [3:0]        in_rs_station,
   input  logic [4:0]        in_register_1,
   input  logic [4:0]        in_register_2,
   input  logic [4:0]        in_register_target,
   input  logic              in_has_register_1,
   input  logic              in_has_register_2,
   input  logic              in_has_target,
   input  logic [15:0]       in_immediate,
   input  logic              in_is_noop,
   input  logic [NUM_RS-1:0] rs_ready,
   output logic [NUM_RS-1:0] rs_valid,
   output logic [5:0]        out_alu_fn,
   output logic [15:0]       out_immediate,
   output logic [4:0]        out_src1_reg,
   output logic [4:0]        out_src2_reg,
   output logic              out_src1_busy,
   output logic              out_src2_busy,
   output logic [TAG_W-1:0]  out_src1_tag,
   output logic [TAG_W-1:0]  out_src2_tag,
   output logic              out_has_target,
   output logic [TAG_W-1:0]  out_dst_tag,
   input  logic              cdb_valid,
   input  logic [TAG_W-1:0]  cdb_tag,
   input  logic              flush
`ifdef DISPATCH_STATS_EN
   ,
   output logic [31:0]       stat_issued,
   output logic [31:0]       stat_stall
`endif
);

   logic              hold_valid_q;
   dispatch_payload_t hold_q;
   dispatch_payload_t new_p;
   dispatch_payload_t vis_p;
   logic [TAG_W-1:0]  tag_cnt_q;
   logic [NUM_RS-1:0] sel_onehot;
   reg_status_t       rd1, rd2;
   reg_status_t       src1_now, src2_now;
   logic              station_ok, capture, alloc_en, sel_ready, issue;
   logic              unused_operation;

   assign unused_operation = ^in_operation;

   always_comb begin
      sel_onehot = '0;
      for (int i = 0; i < NUM_RS; i++)
         sel_onehot[i] = (4'(hold_q.station) == 4'(i + 1));
   end

   assign sel_ready  = |(rs_ready & sel_onehot);
   assign issue      = hold_valid_q && sel_ready && !flush;
   assign in_ready   = !hold_valid_q || issue;
   assign station_ok = (in_rs_station != 4'd0) && (in_rs_station <= 4'(NUM_RS));
   assign capture    = in_valid && in_ready && !in_is_noop && station_ok && !flush;
   assign alloc_en   = capture && in_has_target && (in_register_target != 5'd0);

   reg_status_table u_table (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .rd_addr1   (in_register_1),
      .rd_addr2   (in_register_2),
      .rd_data1   (rd1),
      .rd_data2   (rd2),
      .alloc_en   (alloc_en),
      .alloc_addr (in_register_target),
      .alloc_tag  (tag_cnt_q),
      .cdb_valid  (cdb_valid),
      .cdb_tag    (cdb_tag)
   );

   // Sources are read before this instruction's own destination write lands.
   always_comb begin
      new_p            = '0;
      new_p.station    = rs_id_t'(in_rs_station);
      new_p.alu_fn     = in_alu_fn;
      new_p.immediate  = in_immediate;
      new_p.src1_reg   = in_register_1;
      new_p.src2_reg   = in_register_2;
      new_p.src1       = lookup(in_has_register_1, rd1, cdb_valid, cdb_tag);
      new_p.src2       = lookup(in_has_register_2, rd2, cdb_valid, cdb_tag);
      new_p.has_target = alloc_en;
      new_p.dst_tag    = alloc_en ? tag_cnt_q : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_valid_q <= 1'b0;
         hold_q       <= '0;
         tag_cnt_q    <= '0;
      end else if (flush) begin
         hold_valid_q <= 1'b0;
      end else begin
         if (capture) begin
            hold_valid_q <= 1'b1;
            hold_q       <= new_p;
         end else if (issue) begin
            hold_valid_q <= 1'b0;
         end else begin
            hold_q.src1 <= src1_now;
            hold_q.src2 <= src2_now;
         end
         if (alloc_en)
            tag_cnt_q <= tag_cnt_q + TAG_W'(1);
      end
   end

   assign src1_now = lookup(1'b1, hold_q.src1, cdb_valid, cdb_tag);
   assign src2_now = lookup(1'b1, hold_q.src2, cdb_valid, cdb_tag);
   assign vis_p    = hold_valid_q ? hold_q : '0;

   assign rs_valid       = issue ? sel_onehot : '0;
   assign out_alu_fn     = vis_p.alu_fn;
   assign out_immediate  = vis_p.immediate;
   assign out_src1_reg   = vis_p.src1_reg;
   assign out_src2_reg   = vis_p.src2_reg;
   assign out_src1_busy  = hold_valid_q && src1_now.busy;
   assign out_src2_busy  = hold_valid_q && src2_now.busy;
   assign out_src1_tag   = vis_p.src1.tag;
   assign out_src2_tag   = vis_p.src2.tag;
   assign out_has_target = vis_p.has_target;
   assign out_dst_tag    = vis_p.dst_tag;

`ifdef DISPATCH_STATS_EN
   logic [31:0] stat_issued_q, stat_stall_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stat_issued_q <= '0;
         stat_stall_q  <= '0;
      end else begin
         if (issue && (stat_issued_q != '1))
            stat_issued_q <= stat_issued_q + 32'd1;
         if (hold_valid_q && !sel_ready && (stat_stall_q != '1))
            stat_stall_q <= stat_stall_q + 32'd1;
      end
   end

   assign stat_issued = stat_issued_q;
   assign stat_stall  = stat_stall_q;
`endif

endmodule

// File: tb/tb_dispatch_unit.sv
// Directed bench for dispatch_unit: renaming, CDB clears, stalls, drops, tag wrap,
// flush and mid-stall reset, with hand-computed expectations.
module tb_dispatch_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid, in_ready;
   logic [5:0] in_operation, in_alu_fn;
   logic [3:0] in_rs_station;
   logic [4:0] in_register_1, in_register_2, in_register_target;
   logic       in_has_register_1, in_has_register_2, in_has_target;
   logic [15:0] in_immediate;
   logic       in_is_noop;
   logic [3:0] rs_ready, rs_valid;
   logic [5:0] out_alu_fn;
   logic [15:0] out_immediate;
   logic [4:0] out_src1_reg, out_src2_reg;
   logic       out_src1_busy, out_src2_busy;
   logic [3:0] out_src1_tag, out_src2_tag;
   logic       out_has_target;
   logic [3:0] out_dst_tag;
   logic       cdb_valid;
   logic [3:0] cdb_tag;
   logic       flush;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   dispatch_unit #(.TAG_W(4), .NUM_RS(4)) dut (
      .clk                (clk),
      .rst                (rst),
      .in_valid           (in_valid),
      .in_ready           (in_ready),
      .in_operation       (in_operation),
      .in_alu_fn          (in_alu_fn),
      .in_rs_station      (in_rs_station),
      .in_register_1      (in_register_1),
      .in_register_2      (in_register_2),
      .in_register_target (in_register_target),
      .in_has_register_1  (in_has_register_1),
      .in_has_register_2  (in_has_register_2),
      .in_has_target      (in_has_target),
      .in_immediate       (in_immediate),
      .in_is_noop         (in_is_noop),
      .rs_ready           (rs_ready),
      .rs_valid           (rs_valid),
      .out_alu_fn         (out_alu_fn),
      .out_immediate      (out_immediate),
      .out_src1_reg       (out_src1_reg),
      .out_src2_reg       (out_src2_reg),
      .out_src1_busy      (out_src1_busy),
      .out_src2_busy      (out_src2_busy),
      .out_src1_tag       (out_src1_tag),
      .out_src2_tag       (out_src2_tag),
      .out_has_target     (out_has_target),
      .out_dst_tag        (out_dst_tag),
      .cdb_valid          (cdb_valid),
      .cdb_tag            (cdb_tag),
      .flush              (flush)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
   endtask

   task automatic send(input logic [3:0] st, input logic [4:0] r1, input logic h1,
                       input logic [4:0] r2, input logic h2,
                       input logic [4:0] rt, input logic ht, input logic noop);
      in_valid           = 1'b1;
      in_rs_station      = st;
      in_register_1      = r1;
      in_has_register_1  = h1;
      in_register_2      = r2;
      in_has_register_2  = h2;
      in_register_target = rt;
      in_has_target      = ht;
      in_is_noop         = noop;
      in_alu_fn          = 6'h21;
      in_immediate       = 16'h0000;
   endtask

   task automatic idle();
      in_valid      = 1'b0;
      in_is_noop    = 1'b0;
      in_rs_station = 4'd0;
   endtask

   task automatic next();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; cdb_valid = 1'b0; cdb_tag = 4'd0;
      rs_ready = 4'b1111; in_operation = 6'h09;
      send(4'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      idle();
      repeat (2) @(posedge clk);
      next(); rst = 1'b0; #1;
      check("reset_in_ready", in_ready, 1);
      check("reset_rs_valid", rs_valid, 0);
      check("reset_dst_tag", out_dst_tag, 0);
      check("reset_has_target", out_has_target, 0);

      // addiu r3, r1, 0x10 -> RS1, dst tag 0
      send(4'd1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
      in_alu_fn = 6'h09; in_immediate = 16'h0010;
      #1 check("addiu_in_ready", in_ready, 1);

      // addu r4, r3, r3 -> RS1, dst tag 1; addiu issues this cycle
      next();
      send(4'd1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0);
      #1;
      check("addiu_rs_valid", rs_valid, 4'b0001);
      check("addiu_dst_tag", out_dst_tag, 0);
      check("addiu_alu_fn", out_alu_fn, 6'h09);
      check("addiu_imm", out_immediate, 16'h0010);
      check("addiu_src1_reg", out_src1_reg, 1);
      check("addiu_src1_busy", out_src1_busy, 0);

      next(); idle(); #1;
      check("addu_rs_valid", rs_valid, 4'b0001);
      check("addu_src1_busy", out_src1_busy, 1);
      check("addu_src2_busy", out_src2_busy, 1);
      check("addu_src1_tag", out_src1_tag, 0);
      check("addu_dst_tag", out_dst_tag, 1);
      cdb_valid = 1'b1; cdb_tag = 4'd0; #1;
      check("addu_cdb_src1", out_src1_busy, 0);

      // reader of r3 (cleared) and r4 (tag 1) -> RS2
      next(); cdb_valid = 1'b0;
      send(4'd2, 5'd3, 1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0);
      #1 check("rd_idle_rs_valid", rs_valid, 0);
      next(); idle(); #1;
      check("rd_rs_valid", rs_valid, 4'b0010);
      check("rd_r3_busy", out_src1_busy, 0);
      check("rd_r4_busy", out_src2_busy, 1);
      check("rd_r4_tag", out_src2_tag, 1);
      check("rd_has_target", out_has_target, 0);

      // lw r5 <- (r4) to RS4 with RS4 stalled three cycles; dst tag 2
      next(); rs_ready = 4'b0111;
      send(4'd4, 5'd4, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
      next(); idle(); #1;
      check("stall1_rs_valid", rs_valid, 0);
      check("stall1_in_ready", in_ready, 0);
      check("stall1_src1_busy", out_src1_busy, 1);
      check("stall1_dst_tag", out_dst_tag, 2);
      next(); cdb_valid = 1'b1; cdb_tag = 4'd1; #1;
      check("stall2_rs_valid", rs_valid, 0);
      check("stall2_in_ready", in_ready, 0);
      check("stall2_cdb_src1", out_src1_busy, 0);
      next(); cdb_valid = 1'b0; #1;
      check("stall3_rs_valid", rs_valid, 0);
      check("stall3_src1_held", out_src1_busy, 0);
      next(); rs_ready = 4'b1111; #1;
      check("lw_issue", rs_valid, 4'b1000);
      check("lw_in_ready", in_ready, 1);
      check("lw_dst_tag", out_dst_tag, 2);

      // noop, station 0 and station 5 are consumed without effect
      next(); send(4'd1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1); #1;
      check("noop_in_ready", in_ready, 1);
      next(); send(4'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0); #1;
      check("st0_in_ready", in_ready, 1);
      check("noop_rs_valid", rs_valid, 0);
      next(); send(4'd5, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0); #1;
      check("st0_rs_valid", rs_valid, 0);
      next(); idle(); #1;
      check("st5_rs_valid", rs_valid, 0);
      // r6 untouched, r5 still busy with tag 2; counter still at 3
      send(4'd1, 5'd6, 1'b1, 5'd5, 1'b1, 5'd9, 1'b1, 1'b0);
      next();
      // same-cycle bypass: capture r5 reader while CDB broadcasts tag 2
      send(4'd3, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      cdb_valid = 1'b1; cdb_tag = 4'd2; #1;
      check("drop_r6_busy", out_src1_busy, 0);
      check("drop_dst_tag", out_dst_tag, 3);
      check("drop_rs_valid", rs_valid, 4'b0001);
      next(); cdb_valid = 1'b0; idle(); #1;
      check("bypass_rs_valid", rs_valid, 4'b0100);
      check("bypass_src1_busy", out_src1_busy, 0);

      // twelve allocations take the counter 4..15, the thirteenth wraps to 0
      for (int i = 0; i < 12; i++) begin
         send(4'd1, 5'd0, 1'b0, 5'd0, 1'b0, 5'(10 + i), 1'b1, 1'b0);
         next();
      end
      send(4'd1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd22, 1'b1, 1'b0); #1;
      check("wrap_tag15", out_dst_tag, 15);
      next(); idle(); #1;
      check("wrap_tag0", out_dst_tag, 0);

      // flush while stalled: r23 gets tag 1, then hold and busy bits drop
      next(); rs_ready = 4'b0000;
      send(4'd1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd23, 1'b1, 1'b0);
      next(); idle(); #1;
      check("preflush_in_ready", in_ready, 0);
      flush = 1'b1; #1;
      check("flush_rs_valid", rs_valid, 0);
      next(); flush = 1'b0; rs_ready = 4'b1111; #1;
      check("postflush_in_ready", in_ready, 1);
      check("postflush_rs_valid", rs_valid, 0);
      send(4'd1, 5'd23, 1'b1, 5'd9, 1'b1, 5'd24, 1'b1, 1'b0);
      next(); idle(); #1;
      check("postflush_r23_busy", out_src1_busy, 0);
      check("postflush_r9_busy", out_src2_busy, 0);
      check("postflush_dst_tag", out_dst_tag, 2);

      // reset while stalled on r24 (tag 2)
      next(); rs_ready = 4'b0000;
      send(4'd2, 5'd24, 1'b1, 5'd0, 1'b0, 5'd25, 1'b1, 1'b0);
      next(); idle(); #1;
      check("prerst_src1_busy", out_src1_busy, 1);
      rst = 1'b1;
      next(); rst = 1'b0; #1;
      check("rst_in_ready", in_ready, 1);
      check("rst_rs_valid", rs_valid, 0);
      check("rst_dst_tag", out_dst_tag, 0);
      check("rst_src1_busy", out_src1_busy, 0);
      check("rst_imm", out_immediate, 0);
      rs_ready = 4'b1111;
      send(4'd1, 5'd24, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
      next(); idle(); #1;
      check("rst_r24_busy", out_src1_busy, 0);
      check("rst_cnt_tag", out_dst_tag, 0);

      next();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
